// File: rtl/axi_read_arbiter.sv
// Two-master AXI read-channel arbiter with one outstanding transaction.
// A round-robin winner is captured in IDLE, its AR beat is replayed to the
// slave in ADDR, and the R beats are steered back to that master in DATA.
module axi_read_arbiter (
  input  logic        clk,
  input  logic        rst,
  // master 0 AR
  input  logic [3:0]  ARID_M0,
  input  logic [31:0] ARADDR_M0,
  input  logic [3:0]  ARLEN_M0,
  input  logic [2:0]  ARSIZE_M0,
  input  logic [1:0]  ARBURST_M0,
  input  logic        ARVALID_M0,
  output logic        ARREADY_M0,
  // master 1 AR
  input  logic [3:0]  ARID_M1,
  input  logic [31:0] ARADDR_M1,
  input  logic [3:0]  ARLEN_M1,
  input  logic [2:0]  ARSIZE_M1,
  input  logic [1:0]  ARBURST_M1,
  input  logic        ARVALID_M1,
  output logic        ARREADY_M1,
  // master 0 R
  output logic [3:0]  RID_M0,
  output logic [31:0] RDATA_M0,
  output logic [1:0]  RRESP_M0,
  output logic        RLAST_M0,
  output logic        RVALID_M0,
  input  logic        RREADY_M0,
  // master 1 R
  output logic [3:0]  RID_M1,
  output logic [31:0] RDATA_M1,
  output logic [1:0]  RRESP_M1,
  output logic        RLAST_M1,
  output logic        RVALID_M1,
  input  logic        RREADY_M1,
  // slave AR
  output logic [7:0]  ARID_S,
  output logic [31:0] ARADDR_S,
  output logic [3:0]  ARLEN_S,
  output logic [2:0]  ARSIZE_S,
  output logic [1:0]  ARBURST_S,
  output logic        ARVALID_S,
  input  logic        ARREADY_S,
  // slave R
  input  logic [7:0]  RID_S,
  input  logic [31:0] RDATA_S,
  input  logic [1:0]  RRESP_S,
  input  logic        RLAST_S,
  input  logic        RVALID_S,
  output logic        RREADY_S,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant;       // 0 = M0 owns the transaction, 1 = M1
  logic        last_grant;  // master served by the most recent completed burst
  logic        win;
  logic        any_req;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  beat_cnt;
  logic        sel_rready;
  logic        r_hs;
  logic [1:0]  resp_out;
  logic        unused_rid_hi;

  // A short burst (RLAST before ARLEN beats) is reported to the master as SLVERR
  function automatic logic [1:0] final_resp(input logic [1:0] resp, input logic last,
                                            input logic [3:0] cnt, input logic [3:0] len);
    final_resp = (last && (cnt != len)) ? 2'b10 : resp;
  endfunction

  // Upper RID bits echo the master index; steering already follows the registered grant
  assign unused_rid_hi = ^RID_S[7:4];

  assign any_req    = ARVALID_M0 | ARVALID_M1;
  assign sel_rready = grant ? RREADY_M1 : RREADY_M0;
  assign r_hs       = (state == DATA) && RVALID_S && sel_rready;
  assign resp_out   = final_resp(RRESP_S, RLAST_S, beat_cnt, ar_len);

  // Round-robin pick: on contention the master not served last wins
  always_comb begin
    if (ARVALID_M0 && ARVALID_M1) win = ~last_grant;
    else                          win = ARVALID_M1;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (ARREADY_S) state_nxt = DATA;
      DATA:    if (r_hs && RLAST_S) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, captured AR fields, beat counter and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      ar_id      <= '0;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_size    <= '0;
      ar_burst   <= '0;
      beat_cnt   <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        grant    <= win;
        ar_id    <= win ? ARID_M1    : ARID_M0;
        ar_addr  <= win ? ARADDR_M1  : ARADDR_M0;
        ar_len   <= win ? ARLEN_M1   : ARLEN_M0;
        ar_size  <= win ? ARSIZE_M1  : ARSIZE_M0;
        ar_burst <= win ? ARBURST_M1 : ARBURST_M0;
      end
      if ((state == ADDR) && ARREADY_S) beat_cnt <= '0;
      else if (r_hs)                    beat_cnt <= beat_cnt + 4'd1;
      if (r_hs && RLAST_S) last_grant <= grant;
    end
  end

  // Output decode: slave AR replay, master accept pulse and R steering
  always_comb begin
    ARID_S     = {3'b000, grant, ar_id};
    ARADDR_S   = ar_addr;
    ARLEN_S    = ar_len;
    ARSIZE_S   = ar_size;
    ARBURST_S  = ar_burst;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    RREADY_S   = 1'b0;
    RID_M0     = '0;
    RDATA_M0   = '0;
    RRESP_M0   = '0;
    RLAST_M0   = 1'b0;
    RVALID_M0  = 1'b0;
    RID_M1     = '0;
    RDATA_M1   = '0;
    RRESP_M1   = '0;
    RLAST_M1   = 1'b0;
    RVALID_M1  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ADDR: begin
        ARVALID_S  = 1'b1;
        ARREADY_M0 = ARREADY_S && !grant;
        ARREADY_M1 = ARREADY_S && grant;
      end
      DATA: begin
        RREADY_S = sel_rready;
        if (grant) begin
          RID_M1    = RID_S[3:0];
          RDATA_M1  = RDATA_S;
          RRESP_M1  = resp_out;
          RLAST_M1  = RLAST_S;
          RVALID_M1 = RVALID_S;
        end else begin
          RID_M0    = RID_S[3:0];
          RDATA_M0  = RDATA_S;
          RRESP_M0  = resp_out;
          RLAST_M0  = RLAST_S;
          RVALID_M0 = RVALID_S;
        end
      end
      default: ;
    endcase
  end

endmodule
